// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame and ACK check.
// Define PS2_TX_RETRY_EN to resend the latched byte once after a NACK or timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_ready,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_drive_low,
    output logic       ps2_data_drive_low
);

    typedef enum logic [2:0] {StIdle, StInhibit, StRequest, StBits, StAck} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        clk_drv_q, clk_drv_d;
    logic        dat_drv_q, dat_drv_d;
    logic        clk_meta_q, clk_meta_d;
    logic        clk_sync_q, clk_sync_d;
    logic        clk_prev_q, clk_prev_d;
    logic        dat_meta_q, dat_meta_d;
    logic        dat_sync_q, dat_sync_d;
`ifdef PS2_TX_RETRY_EN
    logic        retry_q, retry_d;
`endif

    logic        clk_fall;
    logic        fail;
    logic [10:0] frame;

    // Wire order: start(0), data LSB first, odd parity, stop(1).
    assign frame    = {1'b1, ~^byte_q, byte_q, 1'b0};
    assign clk_fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        clk_drv_d  = clk_drv_q;
        dat_drv_d  = dat_drv_q;
        clk_meta_d = ps2_clock_in;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_data_in;
        dat_sync_d = dat_meta_q;
        fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                clk_drv_d = 1'b0;
                dat_drv_d = 1'b0;
                if (in_valid && ready_q) begin
                    byte_d    = in_data;
                    state_d   = StInhibit;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    clk_drv_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            StInhibit: begin
                if (cnt_q == INHIBIT_CYCLES - 1) begin
                    state_d   = StRequest;
                    cnt_d     = '0;
                    dat_drv_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRequest: begin
                if (cnt_q == SETUP_CYCLES - 1) begin
                    state_d   = StBits;
                    cnt_d     = '0;
                    idx_d     = '0;
                    clk_drv_d = 1'b0;
                    dat_drv_d = ~frame[0];
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StBits: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    idx_d     = idx_q + 4'd1;
                    dat_drv_d = ~frame[idx_d];
                    if (idx_q == 4'd9) begin
                        state_d = StAck;
                    end
                end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StAck: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (dat_sync_q) begin
                        fail = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                        state_d   = StIdle;
                        clk_drv_d = 1'b0;
                        dat_drv_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // NACK and timeout share one exit; ready/busy stay put until the idle cycle.
        if (fail) begin
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            cnt_d     = '0;
            state_d   = StIdle;
            error_d   = 1'b1;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                state_d   = StInhibit;
                clk_drv_d = 1'b1;
                error_d   = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_drv_q  <= 1'b0;
            dat_drv_q  <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_drv_q  <= clk_drv_d;
            dat_drv_q  <= dat_drv_d;
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign out_ready           = ready_q;
    assign out_busy            = busy_q;
    assign out_done            = done_q;
    assign out_error           = error_q;
    assign ps2_clock_drive_low = clk_drv_q;
    assign ps2_data_drive_low  = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model that clocks frames,
// captures the host bits and answers with ACK/NACK or stalls.
module tb_ps2_host_tx;

    localparam int InhCyc = 100;
    localparam int SetCyc = 16;
    localparam int ToCyc  = 2000;
`ifdef PS2_TX_RETRY_EN
    localparam int FailFrames = 2;
`else
    localparam int FailFrames = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready, out_busy, out_done, out_error;
    logic       ps2_clock_in, ps2_data_in;
    logic       ps2_clock_drive_low, ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clock_in = ~(ps2_clock_drive_low | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhCyc),
        .SETUP_CYCLES  (SetCyc),
        .TIMEOUT_CYCLES(ToCyc)
    ) dut (
        .in_clock           (clk),
        .in_reset           (rst_n),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .out_ready          (out_ready),
        .out_busy           (out_busy),
        .out_done           (out_done),
        .out_error          (out_error),
        .ps2_clock_in       (ps2_clock_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clock_drive_low(ps2_clock_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counts, pulse rules and inhibit/setup phase lengths.
    int  cyc = 0, done_cnt = 0, err_cnt = 0;
    int  t_clk = 0, t_data = 0, t_rel = 0;
    logic prev_cdl = 1'b0, prev_ddl = 1'b0, prev_pulse = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clock_drive_low && !prev_cdl) t_clk = cyc;
        if (ps2_data_drive_low && !prev_ddl && ps2_clock_drive_low) t_data = cyc;
        if (!ps2_clock_drive_low && prev_cdl && ps2_data_drive_low) t_rel = cyc;
        if (out_done) done_cnt++;
        if (out_error) err_cnt++;
        if (out_done || out_error) begin
            check("pulse_exclusive", int'(out_done & out_error), 0);
            check("ready_low_in_pulse", int'(out_ready), 0);
        end
        if (prev_pulse && rst_n) check("ready_after_pulse", int'(out_ready), 1);
        prev_pulse = out_done | out_error;
        prev_cdl   = ps2_clock_drive_low;
        prev_ddl   = ps2_data_drive_low;
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (out_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("ready_before_send", int'(got), 1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_after_accept", int'(out_ready), 0);
        check("busy_after_accept", int'(out_busy), 1);
    endtask

    // Device: wait for request-to-send, then clock n_edges falling edges (40-cycle period).
    task automatic run_frame(input int n_edges, input bit ack, output logic [9:0] cap,
                             output bit stop, output bit ok);
        cap  = '0;
        stop = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ps2_data_drive_low && !ps2_clock_drive_low) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int k = 1; k <= n_edges; k++) begin
                repeat (10) @(negedge clk);
                if (k <= 10) begin
                    cap[k-1] = ps2_data_in;
                end else begin
                    stop         = ps2_data_in;
                    dev_data_low = ack;
                end
                repeat (10) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b0;
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (out_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("return_to_ready", int'(got), 1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] frame;  // captured bit i at index i: start, d0..d7, parity
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] cap;
    bit         stop, ok;
    int         d0, e0, nf, lat;

    initial begin
        vecs[0] = '{data: 8'hED, ack: 1'b1, frame: 10'h3DA, exp_done: 1, exp_err: 0};
        vecs[1] = '{data: 8'h01, ack: 1'b1, frame: 10'h002, exp_done: 1, exp_err: 0};
        vecs[2] = '{data: 8'h00, ack: 1'b1, frame: 10'h200, exp_done: 1, exp_err: 0};
        vecs[3] = '{data: 8'h5A, ack: 1'b0, frame: 10'h2B4, exp_done: 0, exp_err: 1};
        vecs[4] = '{data: 8'hC3, ack: 1'b1, frame: 10'h386, exp_done: 1, exp_err: 0};

        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(out_ready), 1);
        check("rst_busy", int'(out_busy), 0);
        check("rst_done", int'(out_done), 0);
        check("rst_error", int'(out_error), 0);
        check("rst_clk_drv", int'(ps2_clock_drive_low), 0);
        check("rst_dat_drv", int'(ps2_data_drive_low), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_byte(vecs[v].data);
            nf = vecs[v].ack ? 1 : FailFrames;
            for (int f = 0; f < nf; f++) begin
                run_frame(11, vecs[v].ack, cap, stop, ok);
                check("request_seen", int'(ok), 1);
                check("frame_bits", int'(cap), int'(vecs[v].frame));
                check("stop_released", int'(stop), 1);
            end
            wait_idle();
            repeat (5) @(negedge clk);
            check("done_count", done_cnt - d0, vecs[v].exp_done);
            check("error_count", err_cnt - e0, vecs[v].exp_err);
            check("inhibit_len", t_data - t_clk, InhCyc);
            check("setup_len", t_rel - t_data, SetCyc);
            check("idle_clk_drv", int'(ps2_clock_drive_low), 0);
            check("idle_dat_drv", int'(ps2_data_drive_low), 0);
        end

        // Device stalls after edge 4: timeout must release both lines and flag an error.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h55);
        for (int f = 0; f < FailFrames; f++) begin
            run_frame(4, 1'b1, cap, stop, ok);
            check("to_request_seen", int'(ok), 1);
        end
        lat = 0;
        for (int i = 1; i <= 2500; i++) begin
            @(negedge clk);
            if (out_error) begin
                lat = i;
                break;
            end
        end
        check("timeout_in_window", int'(lat >= 1975 && lat <= 1990), 1);
        check("to_clk_drv", int'(ps2_clock_drive_low), 0);
        check("to_dat_drv", int'(ps2_data_drive_low), 0);
        repeat (5) @(negedge clk);
        check("to_error_count", err_cnt - e0, 1);
        check("to_done_count", done_cnt - d0, 0);
        check("to_ready", int'(out_ready), 1);

        // Asynchronous reset while in REQUEST releases both lines before the next edge.
        send_byte(8'h11);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ps2_data_drive_low && ps2_clock_drive_low) begin
                ok = 1'b1;
                break;
            end
        end
        check("reached_request", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_clk_release", int'(ps2_clock_drive_low), 0);
        check("async_dat_release", int'(ps2_data_drive_low), 0);
        check("async_ready", int'(out_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", int'(out_ready), 1);
        d0 = done_cnt;
        send_byte(8'hFF);
        run_frame(11, 1'b1, cap, stop, ok);
        check("ff_frame", int'(cap), 10'h3FE);
        wait_idle();
        repeat (5) @(negedge clk);
        check("ff_done_count", done_cnt - d0, 1);

        // New request held mid-frame must be ignored.
        d0 = done_cnt;
        send_byte(8'h3C);
        fork
            run_frame(11, 1'b1, cap, stop, ok);
            begin
                repeat (20) @(negedge clk);
                in_data  = 8'hA5;
                in_valid = 1'b1;
                repeat (380) @(negedge clk);
                in_valid = 1'b0;
            end
        join
        check("busy_frame", int'(cap), 10'h278);
        wait_idle();
        repeat (200) @(negedge clk);
        check("busy_done_count", done_cnt - d0, 1);
        check("no_second_tx", int'(ps2_clock_drive_low), 0);
        check("still_ready", int'(out_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
